carrd_vrf_wb_sink: RTL and testbench
====================================

// Module: carrd_vrf_wb_sink
// PURPOSE
//  Receiving end of the coprocessor writeback bus. Holds the vector register file, commits
//  full-vector and single-element writes from carrd_writeback, and serves two operand read
//  ports with same-cycle write bypass. Scalar (x_reg) results are queued and handed to the
//  host core over a valid/ready channel; backpressure goes back to writeback as wb_stall.
// PARAMETERS
//  NUM_VREGS  32   number of vector registers (address width clog2(NUM_VREGS))
//  LANE_W     128  width of one writeback data word (reg_wr_data*)
//  NUM_LANES  4    data words per vector; VLEN = LANE_W*NUM_LANES = 512
//  ELEM_W     32   element width for element writes and scalar results
//  XQ_DEPTH   2    scalar writeback queue depth (>=1)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        synchronous, active-high reset
//  v_reg_wr_en    in   1        commit vector write this cycle
//  x_reg_wr_en    in   1        push scalar result this cycle
//  el_wr_en       in   1        qualifies v_reg_wr_en: write one element only
//  wr_addr        in   5        destination register (vector or scalar index)
//  el_idx         in   4        element index for el_wr_en (0..VLEN/ELEM_W-1)
//  reg_wr_data    in   128      data word 0 (bits 127:0 of vector)
//  reg_wr_data_2  in   128      data word 1 (bits 255:128)
//  reg_wr_data_3  in   128      data word 2 (bits 383:256)
//  reg_wr_data_4  in   128      data word 3 (bits 511:384)
//  rd_addr_a/_b   in   5        operand read addresses
//  rd_data_a/_b   out  512      operand read data (combinational)
//  x_wb_valid     out  1        scalar result available
//  x_wb_ready     in   1        host core accepts scalar result
//  x_wb_addr      out  5        scalar destination register
//  x_wb_data      out  32       scalar result value
//  wb_stall       out  1        scalar queue cannot accept a push this cycle
//  xq_overflow    out  1        sticky: scalar push was dropped
// BEHAVIOUR
//  Reset: all NUM_VREGS registers <= 0, queue emptied, x_wb_valid=0, xq_overflow=0; outputs
//   reflect reset state the cycle after rst is sampled high. Reset mid-transfer discards
//   queued results; no handshake completes in the reset cycle.
//  Vector write: v_reg_wr_en & !el_wr_en -> vreg[wr_addr] <= {d4,d3,d2,d1} at next edge.
//  Element write: v_reg_wr_en & el_wr_en -> only bits [el_idx*32 +: 32] <= reg_wr_data[31:0];
//   other elements unchanged. el_wr_en without v_reg_wr_en is ignored. v0 is writable.
//  Reads: rd_data_x = vreg[rd_addr_x], zero-latency. Bypass: if v_reg_wr_en and
//   rd_addr_x==wr_addr, rd_data_x returns the post-write value (merged for element write).
//  Scalar queue: FIFO of {addr[4:0], data[31:0]}, entry = {wr_addr, reg_wr_data[31:0]}.
//   Push when x_reg_wr_en & !wb_stall. Pop when x_wb_valid & x_wb_ready. Latency push->valid
//   1 cycle (no flow-through). Head outputs stable while valid & !ready.
//  wb_stall = (count==XQ_DEPTH) & !(x_wb_valid & x_wb_ready); full with same-cycle pop accepts.
//  Push while wb_stall: entry dropped, xq_overflow <= 1 (cleared only by rst).
//  Simultaneous push+pop with 0<count<XQ_DEPTH: count unchanged, order preserved.
//  v_reg_wr_en & x_reg_wr_en both high: both actions performed independently.
//  Pointers wrap modulo XQ_DEPTH; count width clog2(XQ_DEPTH+1).
// STRUCTURE
//  carrd_pkg: VLEN, LANE_W, NUM_VREGS, ELEM_W constants; typedef vreg_t (logic[VLEN-1:0]);
//   typedef struct packed {logic[4:0] addr; logic[31:0] data;} xwb_entry_t.
//  Sub-module carrd_xwb_fifo (parameterised depth, valid/ready out, full/push/pop/overflow).
//  Register array and bypass/merge logic stay in this module.
// TESTING
//  Reset after writes -> all regs read 0, x_wb_valid=0, xq_overflow=0 next cycle.
//  Vector write v5 = {4{128'hA5..}} then read a=5 -> same 512b value; same-cycle read also sees it.
//  v7=all-ones, element write el_idx=3 data 32'h1234_5678 -> bits[127:96]=32'h12345678, rest ones.
//  Push x3=32'h0000_00FF, ready=0 -> valid next cycle, addr=3/data held; ready=1 -> pop, valid=0.
//  Ready=0, push 3 scalars (XQ_DEPTH=2) -> wb_stall=1 on 3rd, xq_overflow=1, queue drains 2 in order.
//  Full queue, push with ready=1 same cycle -> accepted, no overflow, count stays 2.

Source files
------------

// File: rtl/carrd_pkg.sv
// Shared constants and types for the coprocessor writeback sink.
// VLEN is derived from the lane geometry so the two can never disagree.
package carrd_pkg;
   localparam int NUM_VREGS = 32;
   localparam int LANE_W    = 128;
   localparam int NUM_LANES = 4;
   localparam int VLEN      = LANE_W * NUM_LANES;
   localparam int ELEM_W    = 32;
   localparam int NUM_ELEMS = VLEN / ELEM_W;
   localparam int XQ_DEPTH  = 2;
   localparam int VADDR_W   = $clog2(NUM_VREGS);
   localparam int EIDX_W    = $clog2(NUM_ELEMS);

   typedef logic [VLEN-1:0] vreg_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } xwb_entry_t;
endpackage

// File: rtl/carrd_xwb_fifo.sv
// Scalar writeback queue: registered head, no flow-through, with sticky drop flag.
// A full queue still accepts a push when its head is popped in the same cycle.
module carrd_xwb_fifo
   import carrd_pkg::*;
#(
   parameter int DEPTH = XQ_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  xwb_entry_t push_entry,
   output logic       valid,
   input  logic       ready,
   output xwb_entry_t head,
   output logic       full_stall,
   output logic       overflow
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   xwb_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count;
   logic             pop, push_ok;

   assign valid      = (count != '0);
   assign head       = mem[rptr];
   assign pop        = valid & ready;
   assign full_stall = (count == CNT_W'(DEPTH)) & ~pop;
   assign push_ok    = push & ~full_stall;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= push_entry;
            wptr      <= ptr_inc(wptr);
         end
         if (pop)
            rptr <= ptr_inc(rptr);
         if (push_ok & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push_ok)
            count <= count - 1'b1;
         if (push & full_stall)
            overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/carrd_vrf_wb_sink.sv
// Vector register file at the tail of the writeback bus: full/element commits, two
// bypassed read ports, and a queued scalar result channel to the host core.
module carrd_vrf_wb_sink
   import carrd_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               v_reg_wr_en,
   input  logic               x_reg_wr_en,
   input  logic               el_wr_en,
   input  logic [VADDR_W-1:0] wr_addr,
   input  logic [EIDX_W-1:0]  el_idx,
   input  logic [LANE_W-1:0]  reg_wr_data,
   input  logic [LANE_W-1:0]  reg_wr_data_2,
   input  logic [LANE_W-1:0]  reg_wr_data_3,
   input  logic [LANE_W-1:0]  reg_wr_data_4,
   input  logic [VADDR_W-1:0] rd_addr_a,
   input  logic [VADDR_W-1:0] rd_addr_b,
   output logic [VLEN-1:0]    rd_data_a,
   output logic [VLEN-1:0]    rd_data_b,
   output logic               x_wb_valid,
   input  logic               x_wb_ready,
   output logic [4:0]         x_wb_addr,
   output logic [31:0]        x_wb_data,
   output logic               wb_stall,
   output logic               xq_overflow
);
   vreg_t                            vregs [NUM_VREGS];
   logic [NUM_LANES-1:0][LANE_W-1:0] wr_lanes;
   vreg_t                            wr_val;
   xwb_entry_t                       xq_in, xq_head;

   assign wr_lanes = {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data};

   // Post-write value of the destination; shared by the commit and the read bypass.
   always_comb begin
      wr_val = wr_lanes;
      if (el_wr_en) begin
         wr_val = vregs[wr_addr];
         for (int e = 0; e < NUM_ELEMS; e++)
            if (el_idx == EIDX_W'(e))
               wr_val[e*ELEM_W +: ELEM_W] = reg_wr_data[ELEM_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VREGS; i++)
            vregs[i] <= '0;
      end else if (v_reg_wr_en) begin
         vregs[wr_addr] <= wr_val;
      end
   end

   assign rd_data_a = (v_reg_wr_en && rd_addr_a == wr_addr) ? wr_val : vregs[rd_addr_a];
   assign rd_data_b = (v_reg_wr_en && rd_addr_b == wr_addr) ? wr_val : vregs[rd_addr_b];

   assign xq_in.addr = wr_addr;
   assign xq_in.data = reg_wr_data[31:0];

   carrd_xwb_fifo #(.DEPTH(XQ_DEPTH)) u_xq (
      .clk        (clk),
      .rst        (rst),
      .push       (x_reg_wr_en),
      .push_entry (xq_in),
      .valid      (x_wb_valid),
      .ready      (x_wb_ready),
      .head       (xq_head),
      .full_stall (wb_stall),
      .overflow   (xq_overflow)
   );

   assign x_wb_addr = xq_head.addr;
   assign x_wb_data = xq_head.data;
endmodule

// File: tb/tb_carrd_vrf_wb_sink.sv
// Randomised bench for carrd_vrf_wb_sink against a register-array + queue reference model.
module tb_carrd_vrf_wb_sink;
   localparam int XQD = 2;

   logic         clk = 1'b0;
   logic         rst, v_en, x_en, el_en, rdy;
   logic [4:0]   waddr, ra, rb;
   logic [3:0]   eidx;
   logic [511:0] d;
   logic [511:0] rd_data_a, rd_data_b;
   logic         x_wb_valid, wb_stall, xq_overflow;
   logic [4:0]   x_wb_addr;
   logic [31:0]  x_wb_data;

   int tests = 0, fails = 0;

   // reference model state
   logic [511:0] m_regs [32];
   logic [36:0]  m_q [$];
   logic         m_ovf;

   always #5 clk = ~clk;

   carrd_vrf_wb_sink dut (
      .clk(clk), .rst(rst), .v_reg_wr_en(v_en), .x_reg_wr_en(x_en), .el_wr_en(el_en),
      .wr_addr(waddr), .el_idx(eidx),
      .reg_wr_data(d[127:0]), .reg_wr_data_2(d[255:128]),
      .reg_wr_data_3(d[383:256]), .reg_wr_data_4(d[511:384]),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .x_wb_valid(x_wb_valid), .x_wb_ready(rdy), .x_wb_addr(x_wb_addr),
      .x_wb_data(x_wb_data), .wb_stall(wb_stall), .xq_overflow(xq_overflow)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] post_write(input logic [4:0] a);
      logic [511:0] v;
      v = m_regs[a];
      if (el_en) v[eidx*32 +: 32] = d[31:0];
      else       v = d;
      return v;
   endfunction

   // One clock: drive, check outputs mid-cycle against the model, advance the model.
   task automatic cyc(input logic r, input logic ve, input logic xe, input logic ee,
                      input logic [4:0] a, input logic [3:0] ei, input logic [511:0] dd,
                      input logic [4:0] pa, input logic [4:0] pb, input logic rr,
                      input bit check);
      logic pop, stall;
      rst = r; v_en = ve; x_en = xe; el_en = ee; waddr = a; eidx = ei; d = dd;
      ra = pa; rb = pb; rdy = rr;
      @(negedge clk);
      pop   = (m_q.size() != 0) && rr;
      stall = (m_q.size() == XQD) && !pop;
      if (check) begin
         chk("rd_a", rd_data_a, (ve && pa == a) ? post_write(a) : m_regs[pa]);
         chk("rd_b", rd_data_b, (ve && pb == a) ? post_write(a) : m_regs[pb]);
         chk("x_valid", x_wb_valid, m_q.size() != 0);
         if (m_q.size() != 0) chk("x_head", {x_wb_addr, x_wb_data}, m_q[0]);
         chk("wb_stall", wb_stall, stall);
         chk("xq_ovf", xq_overflow, m_ovf);
      end
      if (r) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (ve) m_regs[a] = post_write(a);
         if (pop) void'(m_q.pop_front());
         if (xe) begin
            if (stall) m_ovf = 1'b1;
            else       m_q.push_back({a, dd[31:0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [511:0] pat, ones;
      pat  = {128{4'hA}} ^ {128{4'hF}} ^ {128{4'hF}};
      pat  = {4{ {32{4'hA}} ^ {32{4'h0}} ^ 128'h5 ^ 128'h5 }};
      ones = '1;
      m_ovf = 1'b0;
      foreach (m_regs[i]) m_regs[i] = '0;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 1);

      // full-vector write with same-cycle bypass, then a plain read
      cyc(0, 1, 0, 0, 5'd5, 0, pat, 5'd5, 5'd6, 0, 1);
      chk("v5_const", rd_data_a, {4{ {32{4'hA}} }});
      cyc(0, 0, 0, 0, 0, 0, '0, 5'd5, 5'd5, 0, 1);

      // element write merges one 32-bit slot
      cyc(0, 1, 0, 0, 5'd7, 0, ones, 5'd7, 5'd0, 0, 1);
      cyc(0, 1, 0, 1, 5'd7, 4'd3, {480'h0, 32'h1234_5678}, 5'd7, 5'd7, 0, 1);
      chk("el_merge", rd_data_a, {{384{1'b1}}, 32'h1234_5678, {96{1'b1}}});
      cyc(0, 0, 0, 1, 5'd7, 4'd0, '0, 5'd7, 5'd5, 0, 1);

      // single scalar: held while not ready, popped on ready
      cyc(0, 0, 1, 0, 5'd3, 0, 512'hFF, 0, 0, 0, 1);
      chk("x3_addr", x_wb_addr, 5'd3);
      chk("x3_data", x_wb_data, 32'hFF);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, 1);
      chk("x3_gone", x_wb_valid, 1'b0);

      // overflow on third push with ready low, then drain
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 1, 0, 5'(10 + i), 0, 512'(32'hC0 + i), 0, 0, 0, 1);
      chk("ovf_set", xq_overflow, 1'b1);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, 1);

      // full queue with same-cycle pop accepts the push
      cyc(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 5'd1, 0, 512'h11, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 5'd2, 0, 512'h22, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 5'd4, 0, 512'h44, 0, 0, 1, 1);
      chk("full_pop_ovf", xq_overflow, 1'b0);
      chk("full_pop_head", x_wb_addr, 5'd2);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, 1);

      // reset after writes clears everything
      cyc(0, 1, 1, 0, 5'd9, 0, ones, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, '0, 5'd9, 5'd5, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, '0, 5'd9, 5'd7, 0, 1);
      chk("rst_v9", rd_data_a, '0);

      // random traffic on a small address window to exercise bypass and queue races
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             5'($urandom_range(0, 7)), 4'($urandom), rnd512(),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 2) != 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
